// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared memory widths, wait-counter width, arbiter states and grant ids
package mem_port_arbiter_pkg;
  localparam int MEM_ADDR_SIZE = 8;
  localparam int MEM_WORD_SIZE = 16;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
  typedef enum logic {GRANT_FETCH, GRANT_LS} grant_t;
endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// mem_wait_counter: loadable down-counter with zero flag sequencing memory wait states
module mem_wait_counter import mem_port_arbiter_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - CNT_W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store requesters (MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break)
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
  parameter int ADDR_WIDTH  = MEM_ADDR_SIZE,
  parameter int DATA_WIDTH  = MEM_WORD_SIZE,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  ls_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY %0d outside 1..15", MEM_LATENCY);
  end
  arb_state_t state, state_nxt;
  grant_t grant, winner;
  logic is_store, cnt_zero, any_req, start;
  assign any_req = if_req | ls_req;
  assign start = state == ARB_IDLE && any_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  grant_t last_grant;
  always_ff @(posedge clk)
    if (rst) last_grant <= GRANT_FETCH;
    else if (start) last_grant <= winner;
  assign winner = (if_req && ls_req) ? (last_grant == GRANT_LS ? GRANT_FETCH : GRANT_LS)
                                     : (ls_req ? GRANT_LS : GRANT_FETCH);
`else
  assign winner = ls_req ? GRANT_LS : GRANT_FETCH;
`endif
  mem_wait_counter u_wait (
    .clk,
    .rst,
    .load(start),
    .load_val(CNT_W'(MEM_LATENCY - 1)),
    .dec(state == ARB_ACCESS),
    .zero(cnt_zero)
  );
  always_ff @(posedge clk) state <= rst ? ARB_IDLE : state_nxt;
  always_comb begin
    state_nxt = state == ARB_IDLE   ? (any_req ? ARB_ACCESS : ARB_IDLE) :
                state == ARB_ACCESS ? (cnt_zero ? ARB_RESP : ARB_ACCESS) : ARB_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      grant     <= GRANT_FETCH;
      is_store  <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      mem_we <= start && winner == GRANT_LS && ls_we;
      if (start) begin
        grant    <= winner;
        is_store <= winner == GRANT_LS && ls_we;
        mem_addr <= winner == GRANT_LS ? ls_addr : if_addr;
        if (winner == GRANT_LS) mem_wdata <= ls_wdata;
      end
      if (state == ARB_ACCESS && cnt_zero) begin
        if (grant == GRANT_FETCH) if_rdata <= mem_rdata;
        else if (!is_store) ls_rdata <= mem_rdata;
      end
    end
  assign if_ack = state == ARB_RESP && grant == GRANT_FETCH;
  assign ls_ack = state == ARB_RESP && grant == GRANT_LS;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, latency, store/load data and reset abort
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic        if_req_1, ls_req_1, ls_we_1, if_ack_1, ls_ack_1, mem_we_1;
  logic [7:0]  if_addr_1, ls_addr_1, mem_addr_1;
  logic [15:0] ls_wdata_1, if_rdata_1, ls_rdata_1, mem_wdata_1, mem_rdata_1;
  logic        if_req_3, ls_req_3, ls_we_3, if_ack_3, ls_ack_3, mem_we_3;
  logic [7:0]  if_addr_3, ls_addr_3, mem_addr_3;
  logic [15:0] ls_wdata_3, if_rdata_3, ls_rdata_3, mem_wdata_3, mem_rdata_3;
  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ack(if_ack_1),
    .ls_req(ls_req_1), .ls_we(ls_we_1), .ls_addr(ls_addr_1), .ls_wdata(ls_wdata_1),
    .ls_rdata(ls_rdata_1), .ls_ack(ls_ack_1),
    .mem_addr(mem_addr_1), .mem_we(mem_we_1), .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1)
  );
  mem_port_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .MEM_LATENCY(3)) u3 (
    .clk(clk), .rst(rst),
    .if_req(if_req_3), .if_addr(if_addr_3), .if_rdata(if_rdata_3), .if_ack(if_ack_3),
    .ls_req(ls_req_3), .ls_we(ls_we_3), .ls_addr(ls_addr_3), .ls_wdata(ls_wdata_3),
    .ls_rdata(ls_rdata_3), .ls_ack(ls_ack_3),
    .mem_addr(mem_addr_3), .mem_we(mem_we_3), .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3)
  );
  function automatic logic [15:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hA5C3;
      8'h40:   return 16'hBEEF;
      8'h41:   return 16'h1111;
      default: return {a, ~a};
    endcase
  endfunction
  logic [15:0] d1 [256];
  logic        wr1 [256];
  logic [15:0] d3 [256];
  logic        wr3 [256];
  logic [15:0] r0_3, r1_3;
  assign mem_rdata_1 = wr1[mem_addr_1] ? d1[mem_addr_1] : init_word(mem_addr_1);
  assign mem_rdata_3 = r1_3;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        wr1[i] <= 1'b0;
        wr3[i] <= 1'b0;
      end
    end else begin
      if (mem_we_1) begin
        d1[mem_addr_1]  <= mem_wdata_1;
        wr1[mem_addr_1] <= 1'b1;
      end
      if (mem_we_3) begin
        d3[mem_addr_3]  <= mem_wdata_3;
        wr3[mem_addr_3] <= 1'b1;
      end
    end
    r0_3 <= wr3[mem_addr_3] ? d3[mem_addr_3] : init_word(mem_addr_3);
    r1_3 <= r0_3;
  end
  always @(negedge clk) if (rst === 1'b0) begin
    checks++;
    if ((if_ack_1 & ls_ack_1) !== 1'b0 || (if_ack_3 & ls_ack_3) !== 1'b0) begin
      errors++;
      $display("FAIL ack_exclusive: u1 if/ls=%b%b u3 if/ls=%b%b, required never both high",
               if_ack_1, ls_ack_1, if_ack_3, ls_ack_3);
    end
  end
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_ack_1, ls_ack_1, mem_we_1, mem_addr_1, mem_wdata_1, if_rdata_1, ls_rdata_1} !== '0) begin
      errors++;
      $display("FAIL reset_u1: ack=%b%b we=%b addr=%h wdata=%h ifr=%h lsr=%h, required all 0",
               if_ack_1, ls_ack_1, mem_we_1, mem_addr_1, mem_wdata_1, if_rdata_1, ls_rdata_1);
    end
    checks++;
    if ({if_ack_3, ls_ack_3, mem_we_3, mem_addr_3, mem_wdata_3, if_rdata_3, ls_rdata_3} !== '0) begin
      errors++;
      $display("FAIL reset_u3: ack=%b%b we=%b addr=%h wdata=%h ifr=%h lsr=%h, required all 0",
               if_ack_3, ls_ack_3, mem_we_3, mem_addr_3, mem_wdata_3, if_rdata_3, ls_rdata_3);
    end
    rst = 1'b0;
  endtask
  task automatic test_fetch;
    int n;
    logic ls_seen;
    @(negedge clk);
    if_addr_1 = 8'h10;
    if_req_1 = 1'b1;
    n = 0;
    ls_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      ls_seen |= ls_ack_1;
      if (n == 1) begin
        checks++;
        if (mem_addr_1 !== 8'h10 || mem_we_1 !== 1'b0) begin
          errors++;
          $display("FAIL fetch_access: addr=%h we=%b, required addr=10 we=0", mem_addr_1, mem_we_1);
        end
      end
    end while (!if_ack_1 && n < 20);
    if_req_1 = 1'b0;
    checks++;
    if (n !== 2 || if_ack_1 !== 1'b1) begin
      errors++;
      $display("FAIL fetch_latency: ack after %0d cycles (ack=%b), required 2", n, if_ack_1);
    end
    checks++;
    if (if_rdata_1 !== 16'hA5C3) begin
      errors++;
      $display("FAIL fetch_data: got %h, required a5c3", if_rdata_1);
    end
    @(negedge clk);
    ls_seen |= ls_ack_1;
    checks++;
    if (if_ack_1 !== 1'b0 || if_rdata_1 !== 16'hA5C3 || ls_seen !== 1'b0) begin
      errors++;
      $display("FAIL fetch_after: if_ack=%b rdata=%h ls_seen=%b, required 0/a5c3/0", if_ack_1, if_rdata_1, ls_seen);
    end
  endtask
  task automatic test_store_load;
    int n;
    int we_n;
    logic bus_ok;
    @(negedge clk);
    ls_addr_1 = 8'h20;
    ls_wdata_1 = 16'h1234;
    ls_we_1 = 1'b1;
    ls_req_1 = 1'b1;
    n = 0;
    we_n = 0;
    bus_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (mem_we_1) begin
        we_n++;
        if (mem_addr_1 !== 8'h20 || mem_wdata_1 !== 16'h1234) bus_ok = 1'b0;
      end
    end while (!ls_ack_1 && n < 20);
    ls_req_1 = 1'b0;
    ls_we_1 = 1'b0;
    checks++;
    if (n !== 2 || we_n !== 1 || bus_ok !== 1'b1) begin
      errors++;
      $display("FAIL store_strobe: ack after %0d, we cycles %0d, bus_ok %b, required 2/1/1", n, we_n, bus_ok);
    end
    checks++;
    if (wr1[8'h20] !== 1'b1 || d1[8'h20] !== 16'h1234 || ls_rdata_1 !== 16'h0000) begin
      errors++;
      $display("FAIL store_effect: mem[20]=%h written=%b ls_rdata=%h, required 1234/1/0000",
               d1[8'h20], wr1[8'h20], ls_rdata_1);
    end
    @(negedge clk);
    ls_req_1 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ls_ack_1 && n < 20);
    ls_req_1 = 1'b0;
    checks++;
    if (n !== 2 || ls_rdata_1 !== 16'h1234) begin
      errors++;
      $display("FAIL load_back: ack after %0d data %h, required 2/1234", n, ls_rdata_1);
    end
  endtask
  task automatic test_tie;
    int n;
    int t_if;
    int t_ls;
    int exp_if;
    int exp_ls;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_if = 2;
    exp_ls = 5;
`else
    exp_if = 5;
    exp_ls = 2;
`endif
    @(negedge clk);
    if_addr_1 = 8'h10;
    ls_addr_1 = 8'h20;
    ls_we_1 = 1'b0;
    if_req_1 = 1'b1;
    ls_req_1 = 1'b1;
    n = 0;
    t_if = 0;
    t_ls = 0;
    while (n < 20 && (t_if == 0 || t_ls == 0)) begin
      @(negedge clk);
      n++;
      if (if_ack_1 && t_if == 0) begin
        t_if = n;
        if_req_1 = 1'b0;
      end
      if (ls_ack_1 && t_ls == 0) begin
        t_ls = n;
        ls_req_1 = 1'b0;
      end
    end
    if_req_1 = 1'b0;
    ls_req_1 = 1'b0;
    checks++;
    if (t_if !== exp_if || t_ls !== exp_ls) begin
      errors++;
      $display("FAIL tie_order: fetch ack %0d ls ack %0d, required %0d/%0d", t_if, t_ls, exp_if, exp_ls);
    end
    checks++;
    if (if_rdata_1 !== 16'hA5C3 || ls_rdata_1 !== 16'h1234) begin
      errors++;
      $display("FAIL tie_data: if %h ls %h, required a5c3/1234", if_rdata_1, ls_rdata_1);
    end
  endtask
  task automatic test_back_to_back;
    int k;
    int t [3];
    logic [15:0] dat [3];
    logic addr_ok;
    logic ls_seen;
    @(negedge clk);
    if_addr_3 = 8'h40;
    if_req_3 = 1'b1;
    k = 0;
    addr_ok = 1'b1;
    ls_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t[i] = 0;
      dat[i] = '0;
    end
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) if_addr_3 = 8'h41;
      if (n <= 3 && mem_addr_3 !== 8'h40) addr_ok = 1'b0;
      if (n >= 6 && n <= 8 && mem_addr_3 !== 8'h41) addr_ok = 1'b0;
      ls_seen |= ls_ack_3;
      if (if_ack_3 && k < 3) begin
        t[k] = n;
        dat[k] = if_rdata_3;
        k++;
      end
    end
    if_req_3 = 1'b0;
    checks++;
    if (t[0] !== 4 || t[1] !== 9 || t[2] !== 14) begin
      errors++;
      $display("FAIL b2b_timing: acks at %0d,%0d,%0d, required 4,9,14", t[0], t[1], t[2]);
    end
    checks++;
    if (dat[0] !== 16'hBEEF || dat[1] !== 16'h1111 || dat[2] !== 16'h1111) begin
      errors++;
      $display("FAIL b2b_data: %h,%h,%h, required beef,1111,1111", dat[0], dat[1], dat[2]);
    end
    checks++;
    if (addr_ok !== 1'b1 || ls_seen !== 1'b0) begin
      errors++;
      $display("FAIL b2b_addr: addr_stable=%b ls_seen=%b, required 1/0", addr_ok, ls_seen);
    end
  endtask
  task automatic test_reset_abort;
    int n;
    logic acked;
    @(negedge clk);
    ls_addr_3 = 8'h50;
    ls_wdata_3 = 16'h7777;
    ls_we_3 = 1'b1;
    ls_req_3 = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we_3 !== 1'b1 || mem_addr_3 !== 8'h50 || mem_wdata_3 !== 16'h7777) begin
      errors++;
      $display("FAIL abort_first_access: we=%b addr=%h wdata=%h, required 1/50/7777", mem_we_3, mem_addr_3, mem_wdata_3);
    end
    @(negedge clk);
    rst = 1'b1;
    ls_req_3 = 1'b0;
    ls_we_3 = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_ack_3, ls_ack_3, mem_we_3, mem_addr_3, mem_wdata_3, if_rdata_3, ls_rdata_3} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: ack=%b%b we=%b addr=%h wdata=%h ifr=%h lsr=%h, required all 0",
               if_ack_3, ls_ack_3, mem_we_3, mem_addr_3, mem_wdata_3, if_rdata_3, ls_rdata_3);
    end
    rst = 1'b0;
    acked = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acked |= if_ack_3 | ls_ack_3;
    end
    checks++;
    if (acked !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_ack: ack seen=%b, required 0", acked);
    end
    if_addr_3 = 8'h40;
    if_req_3 = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ack_3 && n < 20);
    if_req_3 = 1'b0;
    checks++;
    if (n !== 4 || if_rdata_3 !== 16'hBEEF) begin
      errors++;
      $display("FAIL abort_recover: ack after %0d data %h, required 4/beef", n, if_rdata_3);
    end
  endtask
  initial begin
    rst = 1'b1;
    {if_req_1, ls_req_1, ls_we_1, if_addr_1, ls_addr_1, ls_wdata_1} = '0;
    {if_req_3, ls_req_3, ls_we_3, if_addr_3, ls_addr_3, ls_wdata_3} = '0;
    test_reset;
    test_fetch;
    test_store_load;
    test_tie;
    test_back_to_back;
    test_reset_abort;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
